// File: rtl/shift_sequencer_if.sv
// Shift sequencer handshake bundle; master drives the request side, slave returns status and result.
// No backpressure signals: requests arriving while the sequencer is busy are simply dropped.
interface shift_sequencer_if #(
   parameter int WIDTH = 32,
   parameter int SHW   = 5
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] operand;
   logic [SHW-1:0]   shamt;
   logic             abort;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;

   modport master (
      output start, op, operand, shamt, abort,
      input  busy, done, result
   );

   modport slave (
      input  start, op, operand, shamt, abort,
      output busy, done, result
   );
endinterface

// File: rtl/shift_sequencer.sv
// Bit-serial shifter: one bit per cycle, done pulse n+1 cycles after an accepted start (n = effective amount).
// No backpressure: start is only looked at in IDLE, so requests made while busy are dropped.
module shift_sequencer #(
   parameter int WIDTH = 32,
   parameter int SHW   = 5
) (
   input  logic            clk,
   input  logic            rst,
   shift_sequencer_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [1:0] OP_SLL  = 2'b00;
   localparam logic [1:0] OP_SRL  = 2'b01;
   localparam logic [1:0] OP_PASS = 2'b10;
   localparam logic [1:0] OP_SRA  = 2'b11;

   state_t           state;
   logic [1:0]       op_q;
   logic [SHW-1:0]   cnt;
   logic [WIDTH-1:0] work;
   logic [WIDTH-1:0] shifted;
   logic             busy_q;
   logic             done_q;

   always_comb begin
      shifted = work;
      case (op_q)
         OP_SLL:  shifted = {work[WIDTH-2:0], 1'b0};
         OP_SRL:  shifted = {1'b0, work[WIDTH-1:1]};
         OP_SRA:  shifted = {work[WIDTH-1], work[WIDTH-1:1]};
         default: shifted = work;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         op_q   <= OP_SLL;
         cnt    <= '0;
         work   <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               // abort outranks start, so a simultaneous request is dropped
               if (bus.start && !bus.abort) begin
                  work   <= bus.operand;
                  op_q   <= bus.op;
                  busy_q <= 1'b1;
                  if (bus.op == OP_PASS || bus.shamt == '0) begin
                     cnt    <= '0;
                     state  <= DONE;
                     done_q <= 1'b1;
                  end else begin
                     cnt    <= bus.shamt;
                     state  <= SHIFT;
                     done_q <= 1'b0;
                  end
               end else begin
                  busy_q <= 1'b0;
                  done_q <= 1'b0;
               end
            end
            SHIFT: begin
               // the aborting edge still shifts, leaving the partial value visible
               work <= shifted;
               cnt  <= cnt - 1'b1;
               if (bus.abort) begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
                  done_q <= 1'b0;
               end else if (cnt <= SHW'(1)) begin
                  state  <= DONE;
                  busy_q <= 1'b1;
                  done_q <= 1'b1;
               end else begin
                  busy_q <= 1'b1;
                  done_q <= 1'b0;
               end
            end
            DONE: begin
               state  <= IDLE;
               busy_q <= 1'b0;
               done_q <= 1'b0;
            end
            default: begin
               state  <= IDLE;
               busy_q <= 1'b0;
               done_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.result = work;

   a_done_implies_busy: assert property (@(posedge clk) disable iff (rst) done_q |-> busy_q);
   a_done_single:       assert property (@(posedge clk) disable iff (rst) done_q |=> !done_q);
endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: vector table plus hand-built abort, reset and busy-start sequences.
module tb_shift_sequencer;
   logic clk;
   logic rst;
   int   n_vec;
   int   n_miss;

   shift_sequencer_if #(.WIDTH(32), .SHW(5)) bus ();

   shift_sequencer #(.WIDTH(32), .SHW(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [1:0]  op;
      logic [31:0] operand;
      logic [4:0]  shamt;
      logic [31:0] exp_res;
      int          exp_lat;
   } vec_t;

   vec_t vecs[10];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // waits at negedges until done, counting cycles after the start edge
   task automatic wait_done(input int m0, output int m, output int busy_cyc);
      m = m0;
      busy_cyc = m0;
      while (bus.done !== 1'b1 && m < 100) begin
         if (bus.busy === 1'b1) busy_cyc++;
         @(negedge clk);
         m++;
      end
      if (bus.busy === 1'b1) busy_cyc++;
   endtask

   task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [4:0] s,
                         input logic [31:0] er, input int en, input string nm);
      int m;
      int bc;
      @(negedge clk);
      bus.start = 1'b1; bus.op = o; bus.operand = a; bus.shamt = s;
      @(negedge clk);
      bus.start = 1'b0; bus.operand = 32'h5A5A_5A5A; bus.shamt = 5'd3;
      wait_done(0, m, bc);
      check({nm, " latency"}, m, en);
      check({nm, " busy_cycles"}, bc, en + 1);
      check({nm, " result"}, bus.result, er);
      @(negedge clk);
      check({nm, " idle_after_done"}, {30'd0, bus.busy, bus.done}, 32'd0);
      check({nm, " result_held"}, bus.result, er);
   endtask

   task automatic watch_quiet(input int cycles, input string nm);
      int dn;
      dn = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (bus.done === 1'b1 || bus.busy === 1'b1) dn++;
      end
      check({nm, " no_spurious_activity"}, dn, 0);
   endtask

   initial begin
      int m;
      int bc;
      n_vec  = 0;
      n_miss = 0;
      vecs[0] = '{2'b00, 32'h0000_0001, 5'd4,  32'h0000_0010, 4};
      vecs[1] = '{2'b11, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 31};
      vecs[2] = '{2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001, 31};
      vecs[3] = '{2'b00, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 0};
      vecs[4] = '{2'b10, 32'hDEAD_BEEF, 5'd7,  32'hDEAD_BEEF, 0};
      vecs[5] = '{2'b11, 32'hF000_0000, 5'd4,  32'hFF00_0000, 4};
      vecs[6] = '{2'b01, 32'hF000_0000, 5'd4,  32'h0F00_0000, 4};
      vecs[7] = '{2'b00, 32'h8000_0001, 5'd1,  32'h0000_0002, 1};
      vecs[8] = '{2'b11, 32'h4000_0000, 5'd30, 32'h0000_0001, 30};
      vecs[9] = '{2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000, 31};

      rst = 1'b0;
      bus.start = 1'b0; bus.op = 2'b00; bus.operand = '0; bus.shamt = '0; bus.abort = 1'b0;
      #1 rst = 1'b1;
      #2;
      check("reset busy", {31'd0, bus.busy}, 32'd0);
      check("reset done", {31'd0, bus.done}, 32'd0);
      check("reset result", bus.result, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 10; i++)
         run_op(vecs[i].op, vecs[i].operand, vecs[i].shamt, vecs[i].exp_res,
                vecs[i].exp_lat, $sformatf("vec%0d", i));

      // second start during SHIFT must be ignored
      @(negedge clk);
      bus.start = 1'b1; bus.op = 2'b00; bus.operand = 32'h1; bus.shamt = 5'd4;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      bus.start = 1'b1; bus.op = 2'b11; bus.operand = 32'hFFFF_FFFF; bus.shamt = 5'd2;
      @(negedge clk);
      bus.start = 1'b0;
      wait_done(2, m, bc);
      check("busy_start latency", m, 4);
      check("busy_start result", bus.result, 32'h0000_0010);
      watch_quiet(8, "busy_start");

      // abort in the second SHIFT cycle of an 8-bit SLL
      @(negedge clk);
      bus.start = 1'b1; bus.op = 2'b00; bus.operand = 32'h1; bus.shamt = 5'd8;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      check("abort busy", {31'd0, bus.busy}, 32'd0);
      check("abort done", {31'd0, bus.done}, 32'd0);
      check("abort result", bus.result, 32'h0000_0004);
      watch_quiet(12, "abort");
      check("abort result_held", bus.result, 32'h0000_0004);

      // reset in the middle of SHIFT clears outputs at once
      @(negedge clk);
      bus.start = 1'b1; bus.op = 2'b00; bus.operand = 32'h1; bus.shamt = 5'd8;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("mid_shift busy_before_rst", {31'd0, bus.busy}, 32'd1);
      rst = 1'b1;
      #1;
      check("rst_mid busy", {31'd0, bus.busy}, 32'd0);
      check("rst_mid done", {31'd0, bus.done}, 32'd0);
      check("rst_mid result", bus.result, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      watch_quiet(12, "rst_mid");

      // first start after reset release is accepted immediately
      run_op(2'b01, 32'h0000_0100, 5'd2, 32'h0000_0040, 2, "post_rst");

      // abort outranks start while idle
      @(negedge clk);
      bus.start = 1'b1; bus.abort = 1'b1; bus.op = 2'b00; bus.operand = 32'h1234; bus.shamt = 5'd3;
      @(negedge clk);
      bus.start = 1'b0; bus.abort = 1'b0;
      check("idle_abort busy", {31'd0, bus.busy}, 32'd0);
      check("idle_abort result", bus.result, 32'h0000_0040);
      watch_quiet(6, "idle_abort");

      // abort while in DONE just returns to IDLE
      @(negedge clk);
      bus.start = 1'b1; bus.op = 2'b10; bus.operand = 32'h0000_0055; bus.shamt = 5'd9;
      @(negedge clk);
      bus.start = 1'b0;
      check("done_abort done_seen", {31'd0, bus.done}, 32'd1);
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      check("done_abort idle", {30'd0, bus.busy, bus.done}, 32'd0);
      check("done_abort result", bus.result, 32'h0000_0055);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits.
REQ-002 Parameter SHW, default 5, shift-amount width; WIDTH SHALL equal 2**SHW.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request to begin a shift; sampled only in IDLE.
REQ-006 op  input  2  operation: 00 SLL, 01 SRL, 11 SRA, 10 pass-through (no shift).
REQ-007 operand  input  WIDTH  value to shift; sampled with start.
REQ-008 shamt  input  SHW  shift amount; sampled with start.
REQ-009 abort  input  1  synchronous kill of an in-flight operation.
REQ-010 busy  output  1  high in SHIFT and DONE states.
REQ-011 done  output  1  one-cycle pulse; result valid.
REQ-012 result  output  WIDTH  shifted value.

Function
REQ-013 The block SHALL implement a 3-state FSM: IDLE, SHIFT, DONE.
REQ-014 The block SHALL perform a multi-bit shift as repeated 1-bit shifts of an internal WIDTH-bit working register, one bit per SHIFT cycle.
REQ-015 IDLE, start=1 at edge k: load working register with operand, latch op, load counter with shamt (or 0 if op=10); next state SHIFT if counter value nonzero, else DONE.
REQ-016 IDLE, start=0: remain IDLE; working register, result unchanged.
REQ-017 SHIFT, each edge: SLL -> {w[WIDTH-2:0],1'b0}; SRL -> {1'b0,w[WIDTH-1:1]}; SRA -> {w[WIDTH-1],w[WIDTH-1:1]}; counter decrements by 1.
REQ-018 SHIFT SHALL transition to DONE on the edge where counter decrements from 1 to 0.
REQ-019 DONE: done=1 for exactly one cycle; next edge -> IDLE unconditionally.
REQ-020 Latency: with start sampled at edge k and effective amount n, done SHALL be high in the cycle following edge k+n (n=0 -> cycle after edge k).
REQ-021 result SHALL equal the working register; it SHALL remain stable from DONE until the next accepted start.
REQ-022 start while busy=1 SHALL be ignored (no queuing, no effect on counter, operand or op).
REQ-023 abort=1 in SHIFT or DONE SHALL force IDLE at next edge, with no done pulse if in SHIFT; result holds the partial working value.
REQ-024 abort=1 in IDLE SHALL have priority over start: start is not accepted that cycle.
REQ-025 shamt=WIDTH-1 SHALL take WIDTH-1 SHIFT cycles; no wrap of counter below 0.
REQ-026 SRA of a negative operand SHALL replicate bit WIDTH-1 for every shifted position.
REQ-027 busy SHALL be low in IDLE, high in SHIFT and DONE.

Reset
REQ-028 rst=1 SHALL immediately (asynchronously) force state IDLE, counter 0, working register 0, busy=0, done=0, result=0.
REQ-029 rst asserted mid-SHIFT SHALL discard the operation; no done pulse after release.
REQ-030 After rst deasserts, the first start SHALL be accepted on the first rising edge with start=1.

Verification
REQ-031 SLL: operand=32'h0000_0001, shamt=4, start -> done in cycle after edge k+4, result=32'h0000_0010, busy high for 5 cycles.
REQ-032 SRA: operand=32'h8000_0000, shamt=31 -> result=32'hFFFF_FFFF after 31 SHIFT cycles; SRL same operand -> 32'h0000_0001.
REQ-033 shamt=0 or op=10, operand=32'hDEAD_BEEF -> done in cycle after edge k, result=32'hDEAD_BEEF.
REQ-034 Second start pulsed during SHIFT with operand=32'hFFFF_FFFF -> ignored; first op's result unaffected.
REQ-035 abort at 2nd SHIFT cycle of shamt=8 SLL of 32'h1 -> IDLE, no done, result=32'h0000_0004; rst mid-SHIFT -> all outputs 0 immediately, no done.
